// File: rtl/mdct_pkg.sv
// Shared constants and FSM encoding for the MDCT coefficient quantize/pack stage.
package mdct_pkg;

    localparam int N_COEF  = 256;
    localparam int ADDR_W  = 9;
    localparam int IN_W    = 16;
    localparam int Q_W     = 8;
    localparam int MAG_W   = IN_W - 1;
    localparam int SHIFT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_CALC = 3'd2,
        ST_HDR  = 3'd3,
        ST_EMIT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/coef_skid_fifo.sv
// Two-entry FIFO holding quantized bytes plus their last flag between BRAM read and stream output.
module coef_skid_fifo
    import mdct_pkg::*;
#(
    parameter int W = Q_W + 1
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Caller never pushes into a full FIFO without a same-cycle pop, nor pops when empty.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/mdct_quant_pack.sv
// Reads a frame of MDCT coefficients twice: peak scan, then block-floating-point quantize
// to bytes streamed out as one header byte followed by N_COEF coefficient bytes.
module mdct_quant_pack
    import mdct_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start,
    output logic              coef_en,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [IN_W-1:0]   coef_rdata,
    output logic [Q_W-1:0]    out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam logic [ADDR_W-1:0]  N_ADDR    = ADDR_W'(N_COEF);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_COEF - 1);
    localparam logic [SHIFT_W-1:0] FRAC_BITS = SHIFT_W'(Q_W - 1);
    localparam logic signed [IN_W:0] SAT_HI  = (IN_W+1)'(127);
    localparam logic signed [IN_W:0] SAT_LO  = -(IN_W+1)'(128);

    function automatic logic [MAG_W-1:0] peak_mag(input logic [IN_W-1:0] x);
        if (x == {1'b1, {(IN_W-1){1'b0}}}) begin
            return {MAG_W{1'b1}};
        end else if (x[IN_W-1]) begin
            return MAG_W'(-x);
        end
        return x[MAG_W-1:0];
    endfunction

    function automatic logic [SHIFT_W-1:0] bit_length(input logic [MAG_W-1:0] v);
        logic [SHIFT_W-1:0] b;
        b = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (v[i]) b = SHIFT_W'(i + 1);
        end
        return b;
    endfunction

    // Round half up, then floor-shift in 17 bits so x=32767 plus rounding cannot wrap.
    function automatic logic [Q_W-1:0] quantize(input logic [IN_W-1:0] x,
                                                 input logic [SHIFT_W-1:0] s);
        logic signed [IN_W:0] t;
        logic signed [IN_W:0] rnd;
        t = $signed({x[IN_W-1], x});
        if (s != '0) begin
            rnd = (IN_W+1)'(1) << (s - SHIFT_W'(1));
            t   = (t + rnd) >>> s;
        end
        if (t > SAT_HI) return 8'h7f;
        if (t < SAT_LO) return 8'h80;
        return t[Q_W-1:0];
    endfunction

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [MAG_W-1:0]   max_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               rvalid_q;
    logic               rlast_q;

    logic [MAG_W-1:0]   mag_in;
    logic [SHIFT_W-1:0] shift_d;
    logic               emitting;
    logic               emit_rd;
    logic               push;
    logic               pop;
    logic [2:0]         occ;
    logic [Q_W:0]       fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [1:0]         fifo_count;

    always_comb begin
        mag_in   = peak_mag(coef_rdata);
        shift_d  = (bit_length(max_q) > FRAC_BITS) ? bit_length(max_q) - FRAC_BITS : '0;
        emitting = (state_q == ST_HDR) || (state_q == ST_EMIT);
        pop      = (state_q == ST_EMIT) && !fifo_empty && out_ready;
        push     = rvalid_q && emitting && (!fifo_full || pop);
        // Count the same-cycle pop so a steady ready stream keeps one read per cycle.
        occ      = 3'(fifo_count) + 3'(rvalid_q) - 3'(pop);
        emit_rd  = emitting && (addr_q != N_ADDR) && (occ < 3'd2);
        coef_en  = ((state_q == ST_SCAN) && (addr_q != N_ADDR)) ||
                   (state_q == ST_CALC) || emit_rd;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            max_q    <= '0;
            shift_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            rvalid_q <= coef_en;
            rlast_q  <= coef_en && (addr_q == LAST_ADDR);
            if ((state_q == ST_SCAN) && rvalid_q && (mag_in > max_q)) begin
                max_q <= mag_in;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SCAN;
                        addr_q  <= '0;
                        max_q   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (addr_q != N_ADDR) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end else begin
                        state_q <= ST_CALC;
                        addr_q  <= '0;
                    end
                end
                ST_CALC: begin
                    shift_q <= shift_d;
                    addr_q  <= ADDR_W'(1);
                    state_q <= ST_HDR;
                end
                ST_HDR: begin
                    if (emit_rd) addr_q <= addr_q + ADDR_W'(1);
                    if (out_ready) state_q <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (emit_rd) addr_q <= addr_q + ADDR_W'(1);
                    if (pop && fifo_head[Q_W]) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    addr_q  <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    coef_skid_fifo #(.W(Q_W + 1)) u_fifo (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({rlast_q, quantize(coef_rdata, shift_q)}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Stream valid/ready: a byte transfers on a cycle with out_valid && out_ready; once
    // out_valid rises, out_data/out_last hold until that transfer.
    always_comb begin
        out_valid = (state_q == ST_HDR) || ((state_q == ST_EMIT) && !fifo_empty);
        out_data  = '0;
        if (state_q == ST_HDR) begin
            out_data = {{(Q_W-SHIFT_W){1'b0}}, shift_q};
        end else if (state_q == ST_EMIT) begin
            out_data = fifo_head[Q_W-1:0];
        end
        out_last  = (state_q == ST_EMIT) && !fifo_empty && fifo_head[Q_W];
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        coef_addr = addr_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_mdct_quant_pack.sv
// Directed bench for mdct_quant_pack: BRAM model, frame driver, expected-byte scoreboard.
module tb_mdct_quant_pack;

    localparam int N = 256;

    logic        clk_in;
    logic        rst_n;
    logic        start;
    logic        coef_en;
    logic [8:0]  coef_addr;
    logic [15:0] coef_rdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    logic [15:0] mem [N];
    logic [7:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    mdct_quant_pack dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .start      (start),
        .coef_en    (coef_en),
        .coef_addr  (coef_addr),
        .coef_rdata (coef_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Clock and synchronous-read BRAM model
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) begin
        if (coef_en) coef_rdata <= mem[coef_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stimulus loaders: memory image plus hand-derived expected stream
    task automatic load_zero();
        exp_q.delete();
        exp_q.push_back(8'h00);
        for (int i = 0; i < N; i++) begin
            mem[i] = 16'h0000;
            exp_q.push_back(8'h00);
        end
    endtask

    task automatic load_ramp();
        int v;
        int e;
        exp_q.delete();
        exp_q.push_back(8'h01);
        for (int i = 0; i < N; i++) begin
            mem[i] = 16'(i - 128);
            v = i - 128 + 1;
            e = (v >= 0) ? v / 2 : -((1 - v) / 2);
            exp_q.push_back(8'(e));
        end
    endtask

    task automatic load_spike();
        exp_q.delete();
        exp_q.push_back(8'h08);
        for (int i = 0; i < N; i++) begin
            mem[i] = (i == 5) ? 16'h7fff : 16'd100;
            exp_q.push_back((i == 5) ? 8'h7f : 8'h00);
        end
    endtask

    task automatic load_neg();
        exp_q.delete();
        exp_q.push_back(8'h08);
        for (int i = 0; i < N; i++) begin
            mem[i] = (i == 0) ? 16'h8000 : 16'h0000;
            exp_q.push_back((i == 0) ? 8'h80 : 8'h00);
        end
    endtask

    // Drives one frame from start; entered and left just after a rising edge.
    task automatic run_frame(input int ready_pct, input int abort_at, input bit timed, input bit poke);
        int         cyc;
        int         acc;
        bit         got_done;
        bit         aborted;
        bit         hdr_seen;
        bit         seen_valid;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [7:0] exp_b;
        acc = 0; got_done = 0; aborted = 0; hdr_seen = 0; seen_valid = 0; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0;
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        cyc = 1;
        while (!got_done && !aborted && cyc < 4000) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            start = poke && (cyc == 40 || cyc == 300);
            #1;
            if (cyc == 1) check("scan_first_read", {busy, coef_en, coef_addr}, {1'b1, 1'b1, 9'd0});
            if (cyc == N + 2) check("calc_read0", {coef_en, coef_addr, out_valid}, {1'b1, 9'd0, 1'b0});
            if (timed && cyc == N + 3) check("hdr_valid_time", out_valid, 1);
            if (prev_stall) check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
            if (seen_valid && coef_en) begin
                checks++;
                assert (int'(coef_addr) <= acc + 2) else begin
                    errors++;
                    $error("FAIL addr_ahead: coef_addr=%0d accepted=%0d limit=%0d", coef_addr, acc, acc + 2);
                end
            end
            if (out_valid) seen_valid = 1;
            if (out_valid && out_ready) begin
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check(hdr_seen ? "coef_byte" : "header_byte", out_data, exp_b);
                    check("last_flag", out_last, exp_q.size() == 0);
                    if (timed && exp_q.size() == 0) check("last_time", cyc, 2 * N + 3);
                end
                if (hdr_seen) acc++;
                hdr_seen = 1;
                if (abort_at >= 0 && acc == abort_at) aborted = 1;
            end
            if (done) begin
                got_done = 1;
                check("bytes_remaining", exp_q.size(), 0);
                if (timed) check("done_time", cyc, 2 * N + 4);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            @(posedge clk_in); #1;
            cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            rst_n = 1'b0;
            #1;
            check("reset_mid_frame",
                  {coef_en, coef_addr, out_data, out_valid, out_last, busy, done, dbg_state}, '0);
        end else begin
            check("frame_timeout", got_done, 1);
            check("idle_after_done", {busy, done, out_valid, dbg_state}, '0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk_in); #1;
        check("reset_values",
              {coef_en, coef_addr, out_data, out_valid, out_last, busy, done, dbg_state}, '0);
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        @(posedge clk_in); #1;

        load_zero();
        run_frame(100, -1, 1, 0);
        load_ramp();
        run_frame(100, -1, 1, 0);
        load_spike();
        run_frame(100, -1, 1, 0);
        load_neg();
        run_frame(100, -1, 1, 0);
        load_ramp();
        run_frame(50, -1, 0, 1);

        load_ramp();
        run_frame(100, 100, 0, 0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        @(posedge clk_in); #1;
        load_ramp();
        run_frame(100, -1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdct_quant_pack.md
# mdct_quant_pack

Downstream stage of the MDCT engine. After the MDCT raises its completion interrupt, this block reads the 256 signed 16-bit coefficients from the coefficient BRAM through a dedicated read port. It then makes two passes over them:
- first pass: find the block peak magnitude;
- second pass: quantize each coefficient to 8 bits with a shared block-floating-point shift.

The result goes out as a byte stream (one header byte, then 256 coefficient bytes) over a valid/ready handshake to the entropy/packing stage.

## Interface
- N_COEF, 256, coefficients per frame
- ADDR_W, 9, coefficient BRAM address width
- IN_W, 16, coefficient width (signed)
- Q_W, 8, quantized width (signed)
- clk_in  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse (driven from MDCT completion); ignored unless IDLE
- coef_en  out  1  BRAM read enable
- coef_addr  out  ADDR_W  BRAM read address, 0..N_COEF-1
- coef_rdata  in  IN_W  BRAM read data, valid the cycle after coef_en
- out_data  out  Q_W  stream byte
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  high with the final coefficient byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- Reset values: coef_en=0, coef_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0; state IDLE.
- States and transitions:
  - IDLE: go to SCAN on start.
  - SCAN: lasts N_COEF+1 cycles. Issues reads 0..N_COEF-1 back to back; the extra cycle drains the last read.
  - CALC: 1 cycle. Registers the shift and issues read 0 for the emit pass.
  - HDR: holds until header accepted.
  - EMIT: holds until the last byte is accepted.
  - DONE: 1 cycle, pulses done.
  - Back to IDLE.
- Peak magnitude (SCAN):
  - mag = |x|; x=-32768 saturates to 32767.
  - Running max is a 15-bit register, cleared on entry to SCAN.
- Shift (CALC):
  - b = bit-length of the max (0 for max=0).
  - shift = max(0, b-(Q_W-1)), range 0..8.
  - Header byte = {4'b0, shift[3:0]}.
- Quantize, per coefficient x in a 17-bit signed intermediate:
  - shift=0: q = x.
  - shift>0: q = (x + 2^(shift-1)) >>> shift (arithmetic, floor).
  - Saturate q to [-128, 127].
- Emit pass:
  - Quantized bytes are pushed into a 2-entry buffer.
  - A read is issued only when buffer occupancy plus in-flight reads is below 2. This means no overflow and full throughput when out_ready=1.
  - out_data/out_valid come from the buffer head; the header is muxed ahead of it while in HDR.
- Stream rules:
  - Once out_valid=1, out_data and out_last hold stable until out_valid&&out_ready.
  - out_valid never deasserts without acceptance.
- start while busy: ignored, no effect on the current frame.
- Reset mid-frame: all state, buffer and counters clear immediately. A partially sent frame is abandoned; the next start produces a complete frame beginning with the header.

## Timing
- Cycle 0: start sampled in IDLE.
- SCAN: cycles 1..N+1, with coef_addr=k in cycle k+1.
- CALC: cycle N+2 (read 0 issued).
- Header: out_valid from cycle N+3.
- With out_ready held 1:
  - byte k is presented in cycle N+4+k;
  - out_last is on cycle 2N+3;
  - done pulses in cycle 2N+4;
  - IDLE from cycle 2N+5.
- For N=256, done is at cycle 516.
- Backpressure only stretches HDR/EMIT; SCAN and CALC are fixed length.
- busy falls in the same cycle IDLE is entered.

## Structure
- Shared package mdct_pkg holds:
  - N_COEF, IN_W, Q_W, ADDR_W constants;
  - state encoding (IDLE, SCAN, CALC, HDR, EMIT, DONE);
  - the shift-width constant.
- One sub-module, coef_skid_fifo:
  - 2-entry, Q_W+1 wide (data + last);
  - push/pop, full/empty, count outputs.
- Bit-length and quantize logic stay as combinational functions in the top.

## Test plan
- All coefficients 0 -> header 0x00, 256 bytes 0x00, out_last on byte 256, done at cycle 516 with out_ready=1.
- coef[i]=i-128 -> header 0x01; byte0 = -64 (0xC0), byte255 = 64 (0x40), byte128 = 0.
- coef[5]=32767, others 100 -> header 0x08; byte5 = 127 (saturated), all others 0.
- coef[0]=-32768, others 0 -> header 0x08; byte0 = 0x80, others 0x00.
- Same data as the ramp case with random out_ready (50%):
  - identical byte sequence, no drop or duplicate;
  - out_data stable while stalled;
  - coef_addr never more than 2 ahead of accepted bytes.
- Reset asserted after 100 emitted bytes -> all outputs at reset values next cycle. start pulses while busy are ignored. A fresh start yields header plus 256 bytes.
